ysyx_22041207_div: RTL

Multi-cycle radix-2 restoring divider, responder side of the ALU's valid/ready long-latency-operation handshake (same protocol as the multiplier: one-cycle request pulse, `*_ready` gating, one-cycle `out_valid`). Serves RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW; both quotient and remainder are produced each operation and the ALU selects one. Instantiated inside the ALU beside the multiplier; the ALU stalls the pipeline via `alu_wait` until `out_valid`.

---
 rtl/ysyx_22041207_div.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22041207_div.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Valid/ready responder: one-cycle request, one-cycle out_valid strobe, flush abort.
module ysyx_22041207_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_valid,
    input  logic        flush,
    input  logic        div_signed,
    input  logic        divw,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        div_ready,
    output logic        out_valid,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    localparam int unsigned W  = 64;
    localparam int unsigned HW = 32;
    localparam int unsigned CW = 7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvd_q, dvd_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic          neg_q_q, neg_q_d;
    logic          neg_r_q, neg_r_d;
    logic          divw_q, divw_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rmd_q, rmd_d;

    function automatic logic [W-1:0] sext32(input logic [HW-1:0] x);
        return {{HW{x[HW-1]}}, x};
    endfunction

    // Accept-time decode: signs, magnitudes and special cases
    logic          a_neg, b_neg, dvs_zero, ovf;
    logic [W-1:0]  a_mag64, b_mag64;
    logic [HW-1:0] a_mag32, b_mag32;

    always_comb begin
        a_neg    = div_signed & (divw ? dividend[HW-1] : dividend[W-1]);
        b_neg    = div_signed & (divw ? divisor[HW-1]  : divisor[W-1]);
        a_mag64  = a_neg ? -dividend : dividend;
        b_mag64  = b_neg ? -divisor  : divisor;
        a_mag32  = a_neg ? -dividend[HW-1:0] : dividend[HW-1:0];
        b_mag32  = b_neg ? -divisor[HW-1:0]  : divisor[HW-1:0];
        dvs_zero = divw ? (divisor[HW-1:0] == '0) : (divisor == '0);
        ovf      = div_signed & (divw ?
                   (dividend[HW-1:0] == 32'h8000_0000 && divisor[HW-1:0] == 32'hFFFF_FFFF) :
                   (dividend == 64'h8000_0000_0000_0000 && divisor == 64'hFFFF_FFFF_FFFF_FFFF));
    end

    // One restoring step; the shifted partial remainder is 65 bits so the compare cannot overflow
    logic [W:0]    rem_sh;
    logic          ge;
    logic [W-1:0]  rem_new, dvd_new;
    logic [HW-1:0] q32, r32;
    logic [W-1:0]  q64, r64, quo_res, rmd_res;

    always_comb begin
        rem_sh  = {rem_q, dvd_q[W-1]};
        ge      = rem_sh >= {1'b0, dvs_q};
        rem_new = ge ? (rem_sh[W-1:0] - dvs_q) : rem_sh[W-1:0];
        dvd_new = {dvd_q[W-2:0], ge};
        q32     = neg_q_q ? -dvd_new[HW-1:0] : dvd_new[HW-1:0];
        r32     = neg_r_q ? -rem_new[HW-1:0] : rem_new[HW-1:0];
        q64     = neg_q_q ? -dvd_new : dvd_new;
        r64     = neg_r_q ? -rem_new : rem_new;
        quo_res = divw_q ? sext32(q32) : q64;
        rmd_res = divw_q ? sext32(r32) : r64;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        divw_d  = divw_q;
        ready_d = ready_q;
        valid_d = 1'b0;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        case (state_q)
            S_IDLE: begin
                if (div_valid && ready_q && !flush) begin
                    ready_d = 1'b0;
                    if (dvs_zero) begin
                        quo_d   = '1;
                        rmd_d   = divw ? sext32(dividend[HW-1:0]) : dividend;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else if (ovf) begin
                        quo_d   = divw ? sext32(dividend[HW-1:0]) : dividend;
                        rmd_d   = '0;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rem_d   = '0;
                        dvd_d   = divw ? {a_mag32, {HW{1'b0}}} : a_mag64;
                        dvs_d   = divw ? {{HW{1'b0}}, b_mag32} : b_mag64;
                        neg_q_d = a_neg ^ b_neg;
                        neg_r_d = a_neg;
                        divw_d  = divw;
                        cnt_d   = divw ? CW'(HW) : CW'(W);
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                rem_d = rem_new;
                dvd_d = dvd_new;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d   = quo_res;
                    rmd_d   = rmd_res;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
        // Abort wins over everything, including a same-cycle request or final step
        if (flush) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
            quo_d   = quo_q;
            rmd_d   = rmd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            divw_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            divw_q  <= divw_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
        end
    end

    assign div_ready = ready_q;
    assign out_valid = valid_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;

endmodule
